// File: rtl/game_round_controller.sv
// Session sequencer above the per-round master FSM: start, scoring, levels, lives, game over.
// Optional build macro GAME_ROUND_BONUS_LIFE_EN grants an extra life on every level-up.
module game_round_controller #(
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 7,
    parameter int LIVES_W          = 3,
    parameter int SCORE_W          = 8,
    parameter int WINS_PER_LEVEL   = 4,
    parameter int MAX_LEVEL        = 7,
    parameter int LEVEL_W          = 3,
    parameter int BASE_SPEED       = 1,
    parameter int SPEED_STEP       = 1,
    parameter int SPEED_W          = 4,
    parameter int GAME_OVER_CYCLES = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key,
    input  logic               round_done,
    input  logic               round_won,
    output logic               game_enable,
    output logic               new_game,
    output logic [LEVEL_W-1:0] level,
    output logic [SPEED_W-1:0] target_speed,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic               game_over,
    output logic [2:0]         state_o
);

    localparam logic [2:0] ST_ATTRACT  = 3'd0;
    localparam logic [2:0] ST_NEW_GAME = 3'd1;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_UPDATE   = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    localparam int TIMER_W  = $clog2(GAME_OVER_CYCLES);
    localparam int STREAK_W = (WINS_PER_LEVEL > 1) ? $clog2(WINS_PER_LEVEL) : 1;
    localparam int WIDE_W   = SPEED_W + LEVEL_W + 1;
    localparam int START_CLAMP = (START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES;

    localparam logic [TIMER_W-1:0]  TIMER_LOAD  = TIMER_W'(GAME_OVER_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_TOP  = STREAK_W'(WINS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LIVES_W-1:0]  LIVES_START = LIVES_W'(START_CLAMP);
    localparam logic [SCORE_W-1:0]  SCORE_MAX   = {SCORE_W{1'b1}};
    localparam logic [WIDE_W-1:0]   SPEED_SAT   = WIDE_W'({SPEED_W{1'b1}});
`ifdef GAME_ROUND_BONUS_LIFE_EN
    localparam logic [LIVES_W-1:0]  LIVES_MAX   = LIVES_W'(MAX_LIVES);
`endif

    logic [2:0]          state_q,  state_d;
    logic [SCORE_W-1:0]  score_q,  score_d;
    logic [LEVEL_W-1:0]  level_q,  level_d;
    logic [LIVES_W-1:0]  lives_q,  lives_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TIMER_W-1:0]  timer_q,  timer_d;
    logic                won_q,    won_d;
    logic                key_q;
    logic                key_rise;
    logic [WIDE_W-1:0]   speed_wide;

    // Only the press edge starts a game, so a held key cannot chain sessions.
    assign key_rise = key & ~key_q;

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        level_d  = level_q;
        lives_d  = lives_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        won_d    = won_q;

        case (state_q)
            ST_ATTRACT: begin
                if (key_rise) begin
                    state_d = ST_NEW_GAME;
                end
            end

            ST_NEW_GAME: begin
                score_d  = '0;
                level_d  = '0;
                streak_d = '0;
                lives_d  = LIVES_START;
                state_d  = ST_PLAY;
            end

            ST_PLAY: begin
                if (round_done) begin
                    won_d   = round_won;
                    state_d = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                if (won_q) begin
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                    if (streak_q == STREAK_TOP) begin
                        streak_d = '0;
                        if (level_q != LEVEL_MAX) begin
                            level_d = level_q + 1'b1;
`ifdef GAME_ROUND_BONUS_LIFE_EN
                            if (lives_q != LIVES_MAX) begin
                                lives_d = lives_q + 1'b1;
                            end
`endif
                        end
                    end else begin
                        streak_d = streak_q + 1'b1;
                    end
                    state_d = ST_PLAY;
                end else begin
                    streak_d = '0;
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        timer_d = TIMER_LOAD;
                        state_d = ST_GAMEOVER;
                    end else begin
                        lives_d = lives_q - 1'b1;
                        state_d = ST_PLAY;
                    end
                end
            end

            ST_GAMEOVER: begin
                // Timer was loaded with N-1 on entry, so this state lasts exactly N cycles.
                if (timer_q == '0) begin
                    state_d = ST_ATTRACT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ATTRACT;
            score_q  <= '0;
            level_q  <= '0;
            lives_q  <= '0;
            streak_q <= '0;
            timer_q  <= '0;
            won_q    <= 1'b0;
            key_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            level_q  <= level_d;
            lives_q  <= lives_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            won_q    <= won_d;
            key_q    <= key;
        end
    end

    // Wide intermediate keeps the product exact before saturating into SPEED_W bits.
    assign speed_wide = WIDE_W'(BASE_SPEED) + WIDE_W'(level_q) * WIDE_W'(SPEED_STEP);
    assign target_speed = (speed_wide > SPEED_SAT) ? {SPEED_W{1'b1}} : speed_wide[SPEED_W-1:0];

    assign game_enable = (state_q == ST_PLAY) || (state_q == ST_UPDATE);
    assign new_game    = (state_q == ST_NEW_GAME);
    assign game_over   = (state_q == ST_GAMEOVER);
    assign score       = score_q;
    assign level       = level_q;
    assign lives       = lives_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Self-checking bench for game_round_controller: session start, levelling, game over, saturation, async reset.
module tb_game_round_controller;

    localparam int START_LIVES      = 3;
    localparam int MAX_LIVES        = 7;
    localparam int LIVES_W          = 3;
    localparam int SCORE_W          = 8;
    localparam int WINS_PER_LEVEL   = 4;
    localparam int MAX_LEVEL        = 7;
    localparam int LEVEL_W          = 3;
    localparam int SPEED_W          = 4;
    localparam int GAME_OVER_CYCLES = 100;
    localparam int W                = SCORE_W + LEVEL_W + LIVES_W;

    localparam logic [2:0] ST_ATTRACT  = 3'd0;
    localparam logic [2:0] ST_PLAY     = 3'd2;
    localparam logic [2:0] ST_UPDATE   = 3'd3;
    localparam logic [2:0] ST_GAMEOVER = 3'd4;

    logic               clk = 1'b0;
    logic               reset;
    logic               key;
    logic               round_done;
    logic               round_won;
    logic               game_enable;
    logic               new_game;
    logic [LEVEL_W-1:0] level;
    logic [SPEED_W-1:0] target_speed;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               game_over;
    logic [2:0]         state_o;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    int m_score, m_level, m_lives, m_streak;

    game_round_controller dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .round_done   (round_done),
        .round_won    (round_won),
        .game_enable  (game_enable),
        .new_game     (new_game),
        .level        (level),
        .target_speed (target_speed),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_game();
        bit seen;
        reset = 1'b1; key = 1'b0; round_done = 1'b0; round_won = 1'b0;
        step(2);
        reset = 1'b0;
        step(1);
        key = 1'b1;
        step(1);
        key = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            if (state_o === ST_PLAY) seen = 1'b1;
            else step(1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL start_game: state=%0d required=%0d", state_o, ST_PLAY);
        end
        m_score = 0; m_level = 0; m_lives = START_LIVES; m_streak = 0;
    endtask

    // Drives one round result; model outcome goes to the scoreboard, checked when UPDATE retires.
    task automatic play_round(input logic won);
        logic [W-1:0] exp_v;
        logic [W-1:0] got;
        bit seen;
        if (won) begin
            if (m_score < 255) m_score++;
            if (m_streak == WINS_PER_LEVEL - 1) begin
                m_streak = 0;
                if (m_level < MAX_LEVEL) begin
                    m_level++;
`ifdef GAME_ROUND_BONUS_LIFE_EN
                    if (m_lives < MAX_LIVES) m_lives++;
`endif
                end
            end else begin
                m_streak++;
            end
        end else begin
            m_streak = 0;
            if (m_lives <= 1) m_lives = 0;
            else m_lives--;
        end
        exp_q.push_back({SCORE_W'(m_score), LEVEL_W'(m_level), LIVES_W'(m_lives)});
        round_done = 1'b1;
        round_won  = won;
        step(1);
        round_done = 1'b0;
        round_won  = 1'($urandom_range(0, 1));
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (state_o === ST_UPDATE) seen = 1'b1;
            else step(1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL round_update_timeout: state=%0d required=%0d", state_o, ST_UPDATE);
        end
        step(1);
        exp_v = exp_q.pop_front();
        got   = {score, level, lives};
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL round_result: score/level/lives=%0d/%0d/%0d required=%0d/%0d/%0d",
                     score, level, lives, exp_v[W-1 -: SCORE_W], exp_v[LIVES_W +: LEVEL_W],
                     exp_v[LIVES_W-1:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; key = 1'b0; round_done = 1'b0; round_won = 1'b0;
        step(2);
        checks++; if (state_o !== ST_ATTRACT) begin errors++; $display("FAIL reset_state: got %0d required 0", state_o); end
        checks++; if (game_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b required 0", game_enable); end
        checks++; if (new_game !== 1'b0) begin errors++; $display("FAIL reset_new_game: got %b required 0", new_game); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b required 0", game_over); end
        checks++; if ({score, level, lives} !== '0) begin errors++; $display("FAIL reset_counters: score/level/lives=%0d/%0d/%0d required 0/0/0", score, level, lives); end
        checks++; if (target_speed !== 4'd1) begin errors++; $display("FAIL reset_speed: got %0d required 1", target_speed); end
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_new_game();
        int pulses;
        pulses = 0;
        key = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (new_game === 1'b1) pulses++;
        end
        key = 1'b0;
        step(1);
        checks++; if (pulses != 1) begin errors++; $display("FAIL new_game_pulses: got %0d required 1", pulses); end
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL new_game_lives: got %0d required 3", lives); end
        checks++; if (score !== 8'd0 || level !== 3'd0) begin errors++; $display("FAIL new_game_score_level: got %0d/%0d required 0/0", score, level); end
        checks++; if (game_enable !== 1'b1) begin errors++; $display("FAIL new_game_enable: got %b required 1", game_enable); end
        checks++; if (target_speed !== 4'd1) begin errors++; $display("FAIL new_game_speed: got %0d required 1", target_speed); end
        m_score = 0; m_level = 0; m_lives = START_LIVES; m_streak = 0;
    endtask

    task automatic test_level_up();
        for (int i = 0; i < 4; i++) play_round(1'b1);
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL level_up_level: got %0d required 1", level); end
        checks++; if (target_speed !== 4'd2) begin errors++; $display("FAIL level_up_speed: got %0d required 2", target_speed); end
        checks++; if (score !== 8'd4) begin errors++; $display("FAIL level_up_score: got %0d required 4", score); end
`ifdef GAME_ROUND_BONUS_LIFE_EN
        checks++; if (lives !== 3'd4) begin errors++; $display("FAIL level_up_lives: got %0d required 4", lives); end
`else
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL level_up_lives: got %0d required 3", lives); end
`endif
    endtask

    task automatic test_streak_reset();
        start_game();
        for (int i = 0; i < 3; i++) play_round(1'b1);
        play_round(1'b0);
        for (int i = 0; i < 3; i++) play_round(1'b1);
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL streak_level: got %0d required 0", level); end
        checks++; if (score !== 8'd6) begin errors++; $display("FAIL streak_score: got %0d required 6", score); end
        checks++; if (lives !== 3'd2) begin errors++; $display("FAIL streak_lives: got %0d required 2", lives); end
        checks++; if (target_speed !== 4'd1) begin errors++; $display("FAIL streak_speed: got %0d required 1", target_speed); end
    endtask

    task automatic test_game_over();
        int cnt;
        int en_bad;
        start_game();
        play_round(1'b1);
        play_round(1'b1);
        for (int i = 0; i < 3; i++) play_round(1'b0);
        checks++; if (state_o !== ST_GAMEOVER) begin errors++; $display("FAIL gameover_entry: state=%0d required %0d", state_o, ST_GAMEOVER); end
        cnt = 0;
        en_bad = 0;
        while (game_over === 1'b1 && cnt < 200) begin
            cnt++;
            if (game_enable !== 1'b0) en_bad++;
            if (cnt == 20) begin round_done = 1'b1; round_won = 1'b1; end
            if (cnt == 21) round_done = 1'b0;
            if (cnt == 50) key = 1'b1;
            if (cnt == 53) key = 1'b0;
            step(1);
        end
        checks++; if (cnt != GAME_OVER_CYCLES) begin errors++; $display("FAIL gameover_length: got %0d cycles required %0d", cnt, GAME_OVER_CYCLES); end
        checks++; if (en_bad != 0) begin errors++; $display("FAIL gameover_enable: got %0d enabled cycles required 0", en_bad); end
        checks++; if (state_o !== ST_ATTRACT) begin errors++; $display("FAIL gameover_exit: state=%0d required 0", state_o); end
        checks++; if (score !== 8'd2 || level !== 3'd0 || lives !== 3'd0) begin errors++; $display("FAIL gameover_persist: score/level/lives=%0d/%0d/%0d required 2/0/0", score, level, lives); end
        // round_done in attract must be ignored
        round_done = 1'b1; round_won = 1'b0;
        step(1);
        round_done = 1'b0;
        step(2);
        checks++; if (score !== 8'd2 || lives !== 3'd0 || state_o !== ST_ATTRACT) begin errors++; $display("FAIL attract_ignore: score/lives/state=%0d/%0d/%0d required 2/0/0", score, lives, state_o); end
        key = 1'b1;
        step(1);
        checks++; if (new_game !== 1'b1) begin errors++; $display("FAIL restart_pulse: got %b required 1", new_game); end
        key = 1'b0;
        step(1);
        checks++; if (state_o !== ST_PLAY || lives !== 3'd3 || score !== 8'd0) begin errors++; $display("FAIL restart_state: state/lives/score=%0d/%0d/%0d required 2/3/0", state_o, lives, score); end
        m_score = 0; m_level = 0; m_lives = START_LIVES; m_streak = 0;
    endtask

    task automatic test_saturation();
        start_game();
        for (int i = 0; i < 40; i++) play_round(1'b1);
        checks++; if (level !== 3'd7) begin errors++; $display("FAIL sat_level: got %0d required 7", level); end
        checks++; if (target_speed !== 4'd8) begin errors++; $display("FAIL sat_speed: got %0d required 8", target_speed); end
        checks++; if (score !== 8'd40) begin errors++; $display("FAIL sat_score40: got %0d required 40", score); end
`ifdef GAME_ROUND_BONUS_LIFE_EN
        checks++; if (lives !== 3'd7) begin errors++; $display("FAIL sat_lives: got %0d required 7", lives); end
`else
        checks++; if (lives !== 3'd3) begin errors++; $display("FAIL sat_lives: got %0d required 3", lives); end
`endif
        for (int i = 0; i < 220; i++) play_round(1'b1);
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_score: got %0d required 255", score); end
    endtask

    task automatic test_async_reset();
        start_game();
        for (int i = 0; i < 3; i++) play_round(1'b0);
        step(30);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL mid_gameover_pre: got %b required 1", game_over); end
        #2 reset = 1'b1;
        #1;
        checks++; if (game_over !== 1'b0 || state_o !== ST_ATTRACT) begin errors++; $display("FAIL async_reset_gameover: game_over/state=%b/%0d required 0/0", game_over, state_o); end
        checks++; if ({score, level, lives} !== '0 || game_enable !== 1'b0) begin errors++; $display("FAIL async_reset_gameover_regs: score/level/lives/en=%0d/%0d/%0d/%b required 0/0/0/0", score, level, lives, game_enable); end
        @(negedge clk);
        reset = 1'b0;
        start_game();
        for (int i = 0; i < 5; i++) play_round(1'b1);
        checks++; if (game_enable !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL mid_play_pre: en/level=%b/%0d required 1/1", game_enable, level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (game_enable !== 1'b0 || new_game !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL async_reset_play_flags: en/ng/go=%b/%b/%b required 0/0/0", game_enable, new_game, game_over); end
        checks++; if ({score, level, lives} !== '0 || target_speed !== 4'd1) begin errors++; $display("FAIL async_reset_play_regs: score/level/lives/speed=%0d/%0d/%0d/%0d required 0/0/0/1", score, level, lives, target_speed); end
        @(negedge clk);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        reset = 1'b1; key = 1'b0; round_done = 1'b0; round_won = 1'b0;
        m_score = 0; m_level = 0; m_lives = 0; m_streak = 0;
        test_reset();
        test_new_game();
        test_level_up();
        test_streak_reset();
        test_game_over();
        test_saturation();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Session-level sequencer above the per-round game master FSM.
- Starts a game on a key press, then gates the master FSM on and off through game_enable.
- Counts wins and losses and raises difficulty by driving the target sprite speed.
- Ends the session when lives run out, shows game over for a fixed time, then returns to attract mode.

Parameters:
- START_LIVES, 3, lives loaded at new game.
- MAX_LIVES, 7, saturation ceiling for lives.
- LIVES_W, 3, width of lives.
- SCORE_W, 8, width of score; score saturates at all-ones.
- WINS_PER_LEVEL, 4, consecutive wins needed to advance a level (must be >= 1).
- MAX_LEVEL, 7, level saturation ceiling.
- LEVEL_W, 3, width of level.
- BASE_SPEED, 1, target speed at level 0.
- SPEED_STEP, 1, speed added per level.
- SPEED_W, 4, width of target_speed.
- GAME_OVER_CYCLES, 100, duration of the game-over display in clk cycles (must be >= 2).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- key  input  1  player button, synchronous level.
- round_done  input  1  one-cycle pulse from the master FSM when the end-of-game timer starts.
- round_won  input  1  round outcome; valid in the same cycle as round_done.
- game_enable  output  1  master FSM is allowed to run rounds.
- new_game  output  1  one-cycle pulse at session start.
- level  output  LEVEL_W  current difficulty level.
- target_speed  output  SPEED_W  target dx magnitude for the next sprite_target_write_dxy.
- score  output  SCORE_W  rounds won this session.
- lives  output  LIVES_W  remaining lives.
- game_over  output  1  game-over display active.

Behaviour:
- Key edge detect: key_r is a register (reset 0); key_rise = key & ~key_r. Only key_rise is used; a held key never retriggers.
- Reset values: state=ATTRACT; score=0, level=0, lives=0, streak=0, timer=0; game_enable=0, new_game=0, game_over=0.
- States and transitions:
  - ATTRACT: game_enable=0. On key_rise go to NEW_GAME.
  - NEW_GAME (one cycle): new_game=1. Registers are loaded on exit: score=0, level=0, streak=0, lives=START_LIVES. Next state is PLAY.
  - PLAY: game_enable=1. On round_done, latch round_won into won_r and go to UPDATE. round_done in any other state is ignored.
  - UPDATE (one cycle): game_enable stays 1.
    - Won: score+1, saturating. If streak==WINS_PER_LEVEL-1, then streak=0 and level+1 saturating at MAX_LEVEL; otherwise streak+1. Next state is PLAY.
    - Lost: streak=0. If lives<=1, set lives=0 and go to GAMEOVER. Otherwise lives-1 and go to PLAY.
  - GAMEOVER: game_enable=0, game_over=1. The timer loads GAME_OVER_CYCLES-1 on entry and counts down; on reaching 0 go to ATTRACT. key is ignored during GAMEOVER.
- Timing: game_over asserts the cycle after UPDATE and stays high for exactly GAME_OVER_CYCLES cycles.
- Persistence: score, level and lives hold their final values through GAMEOVER and ATTRACT until the next NEW_GAME.
- target_speed: computed combinationally from the level register as BASE_SPEED + level*SPEED_STEP, with intermediate width SPEED_W+LEVEL_W+1. The result saturates to 2^SPEED_W-1 on overflow. Because it tracks the level register, it changes one cycle after the UPDATE cycle.
- Latency: round_done at cycle N gives state UPDATE at N+1; updated score, level and lives are visible at N+2.
- Reset mid-operation: asynchronous return to the reset values in any state, including a partially counted GAMEOVER.

Optional Feature:
- Macro: GAME_ROUND_BONUS_LIFE_EN.
- Defined: every UPDATE that increments level (and was not already at MAX_LEVEL) also increments lives, saturating at MAX_LIVES.
- Undefined: lives only ever decrease during a session; no bonus logic is synthesized.

Test Plan:
- Reset, then key held high for 10 cycles -> exactly one new_game pulse; lives=3, score=0, level=0, game_enable=1, target_speed=1.
- 4 round_done pulses with round_won=1 -> score=4, level=1, target_speed=2, streak=0. With GAME_ROUND_BONUS_LIFE_EN defined, lives also becomes 4.
- 3 wins, 1 loss, 3 wins -> level stays 0, score=6, lives=2 (loss resets the streak).
- 3 losses from lives=3 -> after the third loss, game_over=1 for exactly 100 cycles with game_enable=0, then ATTRACT with score and level unchanged. key_rise during GAMEOVER has no effect; key_rise afterwards starts a new game.
- round_done pulsed in ATTRACT and GAMEOVER -> no change to score or lives. 40 consecutive wins -> level saturates at 7, target_speed=8.
- Assert reset mid-GAMEOVER and again mid-PLAY -> all outputs return to their reset values immediately, asynchronously.
